// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants and types for the ripple-carry adder (full_adder) and its
// 1-bit cell (fa_cell).
//
// Contents:
//   FA_DEFAULT_WIDTH : default operand width (a classic 1-bit full adder)
//   FA_MAX_WIDTH     : widest legal operand width
//   fa_result_t      : packed {carry, sum} result, sized for the widest adder
//   fa_make_result   : helper that packs a carry/sum pair into fa_result_t
// -----------------------------------------------------------------------------
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

    // Result of an addition at the widest supported width. Narrower adders
    // zero-extend their sum into this container.
    typedef struct packed {
        logic                    carry;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

    function automatic fa_result_t fa_make_result(
        input logic                    carry,
        input logic [FA_MAX_WIDTH-1:0] sum
    );
        fa_result_t r;
        r.carry = carry;
        r.sum   = sum;
        return r;
    endfunction

endpackage : full_adder_pkg

// File: rtl/fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder; the leaf of the ripple-carry chain
// in full_adder.
//
// Ports:
//   a    in   operand bit A
//   b    in   operand bit B
//   cin  in   carry-in from the next lower bit (or the adder carry-in)
//   s    out  sum bit        = a ^ b ^ cin
//   cout out  carry to next  = (a & b) | (cin & (a ^ b))
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;   // propagate: a carry-in passes straight through when set

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : fa_cell

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Parameterizable ripple-carry adder built from WIDTH fa_cell instances.
// Provides a zero-latency combinational result and a one-cycle registered
// copy qualified by a valid flag.
//
// Parameters:
//   WIDTH      operand width, legal range 1..FA_MAX_WIDTH (64)
//
// Ports:
//   clk        in   rising-edge clock for the registered outputs
//   rst_n      in   asynchronous active-low reset (registered outputs only)
//   a, b       in   WIDTH-bit operands
//   c          in   carry-in
//   in_valid   in   qualifies a/b/c for capture into the registered stage
//   sum        out  combinational sum, modulo 2^WIDTH
//   carry      out  combinational carry-out
//   sum_q      out  registered sum (held while in_valid is low)
//   carry_q    out  registered carry-out
//   out_valid  out  in_valid delayed by one cycle
//   ovf        out  signed overflow, k_WIDTH ^ k_WIDTH-1  (FULL_ADDER_OVF_EN)
//   ovf_q      out  registered ovf                        (FULL_ADDER_OVF_EN)
//
// Build option:
//   FULL_ADDER_OVF_EN  when defined, adds the ovf / ovf_q outputs.
// -----------------------------------------------------------------------------
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf,
    output logic             ovf_q,
`endif
    output logic             out_valid
);

    // -------------------------------------------------------------------------
    // Combinational ripple-carry chain
    // k[i] is the carry into bit i; k[0] is the external carry-in and
    // k[WIDTH] is the carry-out.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s;

    assign k[0] = c;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            fa_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (k[gi]),
                .s    (s[gi]),
                .cout (k[gi+1])
            );
        end
    endgenerate

    // Pack through the shared result type so every width presents the same
    // {carry, sum} view; only the low WIDTH sum bits are meaningful.
    fa_result_t result;

    assign result = fa_make_result(k[WIDTH], FA_MAX_WIDTH'(s));
    assign carry  = result.carry;
    assign sum    = s;

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For WIDTH=1, k[WIDTH-1] is the carry-in itself.
    assign ovf = k[WIDTH] ^ k[WIDTH-1];
`endif

    // -------------------------------------------------------------------------
    // Registered stage
    // The data registers only load when in_valid is set, so the mux below
    // implements hold; out_valid follows in_valid every cycle.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             valid_d;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf_d;
`endif

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = in_valid;
`ifdef FULL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
`ifdef FULL_ADDER_OVF_EN
            ovf_d   = ovf;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            out_valid <= valid_d;
`ifdef FULL_ADDER_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

endmodule : full_adder

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Directed, self-checking bench for full_adder. One WIDTH=1 instance covers
// the classic truth table; one WIDTH=4 instance covers wrap-around, the
// registered stage, asynchronous reset and release timing, and (when
// FULL_ADDER_OVF_EN is defined) the signed-overflow output.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk;
    logic rst_n;

    // WIDTH=1 instance
    logic a1, b1, c1, in_valid1;
    logic sum1, carry1, sum_q1, carry_q1, out_valid1;
`ifdef FULL_ADDER_OVF_EN
    logic ovf1, ovf_q1;
`endif

    // WIDTH=4 instance
    logic [3:0] a4, b4;
    logic       c4, in_valid4;
    logic [3:0] sum4, sum_q4;
    logic       carry4, carry_q4, out_valid4;
`ifdef FULL_ADDER_OVF_EN
    logic ovf4, ovf_q4;
`endif

    int checks;
    int errors;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .in_valid  (in_valid1),
        .sum       (sum1),
        .carry     (carry1),
        .sum_q     (sum_q1),
        .carry_q   (carry_q1),
`ifdef FULL_ADDER_OVF_EN
        .ovf       (ovf1),
        .ovf_q     (ovf_q1),
`endif
        .out_valid (out_valid1)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a4),
        .b         (b4),
        .c         (c4),
        .in_valid  (in_valid4),
        .sum       (sum4),
        .carry     (carry4),
        .sum_q     (sum_q4),
        .carry_q   (carry_q4),
`ifdef FULL_ADDER_OVF_EN
        .ovf       (ovf4),
        .ovf_q     (ovf_q4),
`endif
        .out_valid (out_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Hand-computed WIDTH=1 truth table, indexed by {a,b,c}
    logic [7:0] tt_sum;
    logic [7:0] tt_carry;
    logic [2:0] vec;

    initial begin
        checks    = 0;
        errors    = 0;
        tt_sum    = 8'b1001_0110;   // bit i = sum for {a,b,c}=i
        tt_carry  = 8'b1110_1000;   // bit i = carry for {a,b,c}=i
        rst_n     = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; in_valid1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0; in_valid4 = 1'b0;

        // Reset state
        #12;
        check("rst_sum_q",     64'(sum_q4),     64'd0);
        check("rst_carry_q",   64'(carry_q4),   64'd0);
        check("rst_out_valid", 64'(out_valid4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            vec = 3'(i);
            {a1, b1, c1} = vec;
            #5;
            check($sformatf("w1_sum_%0d", i),   64'(sum1),   64'(tt_sum[i]));
            check($sformatf("w1_carry_%0d", i), 64'(carry1), 64'(tt_carry[i]));
        end

        // WIDTH=4 wrap-around
        a4 = 4'd15; b4 = 4'd0; c4 = 1'b1; #1;
        check("wrap_sum",   64'(sum4),   64'd0);
        check("wrap_carry", 64'(carry4), 64'd1);
        a4 = 4'd9; b4 = 4'd6; c4 = 1'b0; #1;
        check("nowrap_sum",   64'(sum4),   64'd15);
        check("nowrap_carry", 64'(carry4), 64'd0);

        // Registered path: 7+8+1 = 16 -> sum 0, carry 1
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd8; c4 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        check("reg_sum_q",     64'(sum_q4),     64'd0);
        check("reg_carry_q",   64'(carry_q4),   64'd1);
        check("reg_out_valid", 64'(out_valid4), 64'd1);
        @(negedge clk);
        in_valid4 = 1'b0; a4 = 4'd1; b4 = 4'd2; c4 = 1'b0;
        @(posedge clk); #1;
        check("hold_out_valid", 64'(out_valid4), 64'd0);
        check("hold_sum_q",     64'(sum_q4),     64'd0);
        check("hold_carry_q",   64'(carry_q4),   64'd1);

        // Capture 13+8 = 21 -> sum 5, carry 1
        @(negedge clk);
        a4 = 4'd13; b4 = 4'd8; c4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        check("cap5_sum_q",   64'(sum_q4),   64'd5);
        check("cap5_carry_q", 64'(carry_q4), 64'd1);

        // Reset mid-cycle: must clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sum_q",     64'(sum_q4),     64'd0);
        check("async_carry_q",   64'(carry_q4),   64'd0);
        check("async_out_valid", 64'(out_valid4), 64'd0);
        a4 = 4'd1; b4 = 4'd1; c4 = 1'b0; #1;
        check("rst_comb_sum", 64'(sum4), 64'd2);
        @(posedge clk); #1;
        check("rst_hold_sum_q",     64'(sum_q4),     64'd0);
        check("rst_hold_out_valid", 64'(out_valid4), 64'd0);

        // Release with a pending valid input: first rising edge captures 3+3
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd3; c4 = 1'b0; in_valid4 = 1'b1;
        rst_n = 1'b1;
        #1;
        check("rel_pre_out_valid", 64'(out_valid4), 64'd0);
        @(posedge clk); #1;
        check("rel_sum_q",     64'(sum_q4),     64'd6);
        check("rel_out_valid", 64'(out_valid4), 64'd1);

`ifdef FULL_ADDER_OVF_EN
        in_valid4 = 1'b0;
        a4 = 4'd7; b4 = 4'd1; c4 = 1'b0; #1;
        check("ovf_pos_sum", 64'(sum4), 64'd8);
        check("ovf_pos",     64'(ovf4), 64'd1);
        a4 = 4'd8; b4 = 4'd8; c4 = 1'b0; #1;
        check("ovf_neg_sum",   64'(sum4),   64'd0);
        check("ovf_neg_carry", 64'(carry4), 64'd1);
        check("ovf_neg",       64'(ovf4),   64'd1);
        a4 = 4'd3; b4 = 4'd2; c4 = 1'b0; #1;
        check("ovf_none", 64'(ovf4), 64'd0);
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        check("ovf_q", 64'(ovf_q4), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterizable ripple-carry adder built from 1-bit full-adder cells.
- Combinational sum/carry outputs, so the default WIDTH=1 instance is a drop-in classic full adder.
- Also provides a one-cycle registered copy of the result with a valid flag, for pipelined datapaths.
- Used as the basic arithmetic leaf in datapath blocks.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered outputs
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  input  1  carry-in
- in_valid  input  1  qualifies a/b/c for capture into the registered stage
- sum  output  WIDTH  combinational sum bits
- carry  output  1  combinational carry-out
- sum_q  output  WIDTH  registered sum
- carry_q  output  1  registered carry-out
- out_valid  output  1  registered in_valid; marks sum_q/carry_q as holding a new result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Combinational path:
  - {carry, sum} = a + b + c, computed as a WIDTH+1-bit unsigned addition.
  - Zero latency.
  - Independent of clk and rst_n.
- Bit cell i:
  - s_i = a_i ^ b_i ^ k_i
  - k_{i+1} = (a_i & b_i) | (k_i & (a_i ^ b_i))
  - k_0 = c; carry = k_WIDTH.
- WIDTH=1 truth table for {a,b,c} = 0..7:
  - sum = 0,1,1,0,1,0,0,1
  - carry = 0,0,0,1,0,1,1,1
- Wrap-around: the result is modulo 2^WIDTH in sum; the overflow bit appears only on carry. There is no saturation.
- Registered path:
  - On each rising clk, out_valid <= in_valid.
  - When in_valid=1: sum_q <= sum and carry_q <= carry.
  - When in_valid=0: sum_q and carry_q hold their previous value.
  - Latency is exactly 1 cycle.
- Reset:
  - rst_n low immediately (asynchronously) forces sum_q=0, carry_q=0, out_valid=0, and these hold while rst_n is low.
  - The combinational sum/carry remain live during reset.
  - Reset asserted mid-operation discards any in-flight result.
  - The first capture after release occurs at the first rising clk with rst_n high.
- X-handling: no special handling; X on inputs propagates.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- When defined:
  - Adds combinational output ovf (1 bit) = k_WIDTH ^ k_{WIDTH-1}, i.e. two's-complement signed overflow.
  - For WIDTH=1, k_{WIDTH-1} is c.
  - Adds registered ovf_q, captured with sum_q and reset to 0.
- When undefined: neither port exists and the logic is absent.

Decomposition:
- Package full_adder_pkg holds:
  - FA_DEFAULT_WIDTH = 1
  - FA_MAX_WIDTH = 64
  - typedef fa_result_t, a packed struct {carry, sum} sized by FA_MAX_WIDTH.
- Sub-module fa_cell: 1-bit full adder (a, b, cin -> s, cout).
  - full_adder instantiates WIDTH copies in a generate loop and chains cin/cout.
- The registered stage lives in full_adder itself.

Test Plan:
- WIDTH=1, exhaustive: apply {a,b,c} = 0..7, each held for 5 time units, observing combinational outputs. Required: sum=0,1,1,0,1,0,0,1 and carry=0,0,0,1,0,1,1,1.
- WIDTH=4, wrap: a=15, b=0, c=1 -> sum=0, carry=1. Then a=9, b=6, c=0 -> sum=15, carry=0.
- WIDTH=4, registered path: in_valid=1 with a=7, b=8, c=1 at edge N -> at edge N+1, sum_q=0, carry_q=1, out_valid=1. Next cycle in_valid=0 -> out_valid=0 and sum_q holds 0.
- Reset mid-operation: after a capture with sum_q=5, drop rst_n between clock edges. Required:
  - sum_q=0, carry_q=0, out_valid=0 immediately, without waiting for a clock edge.
  - Combinational sum still tracks the inputs.
- Release timing: release rst_n with in_valid=1, a=3, b=3, c=0 -> first rising edge after release gives sum_q=6, out_valid=1.
- With FULL_ADDER_OVF_EN defined, WIDTH=4:
  - a=7, b=1, c=0 -> sum=8, ovf=1.
  - a=8, b=8, c=0 -> sum=0, carry=1, ovf=1.
  - a=3, b=2, c=0 -> ovf=0.
